hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32 core; the counterpart of the control decoder's pipeline registers.
- Consumes the execute/memory/writeback control signals (PCSrcE, ResultSrcE0, RegWriteM, RegWriteW) and register indices.
- Produces forwarding selects, stage stalls and flushes; FlushE feeds back into the decoder's ID/EX control register.
- Adds a data-memory wait FSM with a timeout error flag, plus saturating stall and redirect performance counters.

Parameters:
- CNT_W, 32, width of the StallCnt/FlushCnt performance counters.
- MEM_TIMEOUT, 255, consecutive memory-wait cycles after which MemErr sets.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  source registers in decode.
- Rs1E, Rs2E, RdE  in  5  source/destination registers in execute.
- RdM, RdW  in  5  destination registers in memory and writeback.
- PCSrcE  in  1  branch/jump taken in execute.
- ResultSrcE0  in  1  execute instruction is a load.
- RegWriteM, RegWriteW  in  1  register write enables in M and W.
- MemReqM  in  1  load/store active in M.
- DMemReadyM  in  1  data memory completes the M access this cycle.
- CntClr  in  1  synchronous counter clear.
- ForwardAE, ForwardBE  out  2  ALU operand forward select.
- StallF, StallD, StallE, StallM  out  1  hold stage registers.
- FlushD, FlushE, FlushW  out  1  bubble stage registers.
- MemErr  out  1  sticky memory-timeout flag.
- StallCnt, FlushCnt  out  CNT_W  performance counters.

Behaviour:
- Forwarding is combinational. ForwardAE encodes the Rs1E source:
  - 10 when RegWriteM & RdM!=0 & RdM==Rs1E;
  - else 01 when RegWriteW & RdW!=0 & RdW==Rs1E;
  - else 00.
  - M has priority over W. ForwardBE is identical using Rs2E.
- memStall = MemReqM & ~DMemReadyM, combinational, same cycle.
- lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) & ~PCSrcE. A taken branch kills the wrong-path D instruction, so no load-use stall.
- If memStall:
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - A branch in E is held and its redirect applies on release.
- Else:
  - StallF=StallD=lwStall; StallE=StallM=FlushW=0.
  - FlushD=PCSrcE; FlushE=lwStall|PCSrcE.
- FSM states RUN and WAIT:
  - RUN→WAIT on memStall, with waitCnt=1.
  - WAIT with memStall: waitCnt++ (saturates at MEM_TIMEOUT). When waitCnt reaches MEM_TIMEOUT, MemErr←1.
  - WAIT→RUN when memStall=0, clearing waitCnt.
  - MemErr is cleared only by reset; the stall continues to follow DMemReadyM regardless of MemErr.
- Counters, each saturating at all-ones:
  - StallCnt increments every cycle StallF=1.
  - FlushCnt increments every cycle FlushD=1, i.e. each taken redirect.
  - CntClr zeroes both and wins over a same-cycle increment.
- Reset low (asynchronous): state=RUN, waitCnt=0, MemErr=0, counters=0. Combinational outputs are also forced: all Stall*=0, FlushD=FlushE=FlushW=1, ForwardAE=ForwardBE=00.
- Reset release takes effect on the next clk edge.

Test Plan:
- Forwarding:
  - RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10.
  - RegWriteM=0 → ForwardAE=01.
  - Rs1E=0 with a match on x0 → 00.
- Load-use: ResultSrcE0=1, RdE=3, Rs2D=3, PCSrcE=0 → StallF=StallD=FlushE=1, FlushD=0, StallCnt +1. Same stimulus with PCSrcE=1 → StallF=0, FlushD=FlushE=1, FlushCnt +1.
- Memory wait: MemReqM=1, DMemReadyM=0 for 3 cycles, then 1 → all Stall*=1 and FlushW=1 for exactly 3 cycles, FSM back to RUN, MemErr=0. With PCSrcE=1 during the wait → FlushD=0 during the wait, 1 on the release cycle.
- Timeout: MEM_TIMEOUT=4, ready held low for 6 cycles → MemErr rises on the 4th wait cycle and stays 1 after ready returns, until reset.
- Counters: CNT_W=4, 20 stall cycles → StallCnt=15 (saturated). CntClr asserted together with a stall → StallCnt=0.
- Reset: assert reset low mid-WAIT with MemErr=1 → immediately MemErr=0, counters 0, Stall*=0, Flush*=1. After release plus one edge, normal operation resumes.

Source files
------------

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - RV32 5-stage pipeline hazard unit with memory-wait FSM and perf counters
module hazard_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             PCSrcE,
  input  logic             ResultSrcE0,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             DMemReadyM,
  input  logic             CntClr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [WCW-1:0] r_wait_cnt;
  logic [WCW-1:0] w_wait_next;
  logic           r_mem_err;
  logic           w_mem_err_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_mem_stall;
  logic w_lw_stall;

  assign w_mem_stall = MemReqM & ~DMemReadyM;
  // A taken branch squashes the decode instruction, so it cannot cause a load-use stall
  assign w_lw_stall  = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D)) & ~PCSrcE;

  // Forward selects, stalls and flushes; reset forces a bubble everywhere with no stalls
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (reset) begin
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
      if (w_mem_stall) begin
        // Freeze everything up to M; a branch held in E redirects once memory releases
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end else begin
        StallF = w_lw_stall;
        StallD = w_lw_stall;
        FlushD = PCSrcE;
        FlushE = w_lw_stall | PCSrcE;
        FlushW = 1'b0;
      end
    end
  end

  // Memory-wait next state: count consecutive stall cycles and flag a timeout
  always_comb begin
    w_state_next   = r_state;
    w_wait_next    = r_wait_cnt;
    w_mem_err_next = r_mem_err;
    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_state_next = S_WAIT;
          w_wait_next  = WCW'(1);
        end
      end
      S_WAIT: begin
        if (w_mem_stall) begin
          if (r_wait_cnt < TIMEOUT_V) w_wait_next = r_wait_cnt + WCW'(1);
        end else begin
          w_state_next = S_RUN;
          w_wait_next  = '0;
        end
      end
      default: begin
        w_state_next = S_RUN;
        w_wait_next  = '0;
      end
    endcase
    if (w_mem_stall && (w_wait_next >= TIMEOUT_V)) w_mem_err_next = 1'b1;
  end

  // Memory-wait state register; the error flag is sticky until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      r_mem_err  <= w_mem_err_next;
    end
  end

  // Saturating performance counters; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (CntClr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (FlushD && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign MemErr   = r_mem_err;
  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;

endmodule
